// File: rtl/clk_period_meter_pkg.sv
// Shared types and constants for the clock period meter and its input synchronizer.
package clk_period_meter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned SYNC_STAGES   = 2;

  typedef enum logic {
    MEAS_IDLE = 1'b0,
    MEAS_RUN  = 1'b1
  } meas_state_t;

  // Observation bundle: FSM state plus the synchronized input and its edge flags.
  typedef struct packed {
    meas_state_t state;
    logic        level;
    logic        rise;
    logic        fall;
  } meas_dbg_t;

endpackage

// File: rtl/clk_period_meter_sync.sv
// Multi-flop synchronizer for an asynchronous level plus a one-flop edge register.
module clk_period_meter_sync
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~edge_q;
  assign fall_o  = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned TIMEOUT   = 100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout,
  output meas_dbg_t            dbg_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic level;
  logic rise;
  logic fall;

  meas_state_t          state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] hi_cnt_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] high_q;
  logic                 valid_q;
  logic                 timeout_q;

  clk_period_meter_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (sig_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // A rising edge restarts the counters with hi_cnt=1 because the rise cycle
  // itself is high and belongs to the new period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MEAS_IDLE;
      cnt_q     <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        MEAS_IDLE: begin
          cnt_q    <= '0;
          hi_cnt_q <= '0;
          if (en && rise) begin
            state_q  <= MEAS_RUN;
            hi_cnt_q <= CNT_ONE;
          end
        end
        MEAS_RUN: begin
          // Priority: disable beats an edge, an edge beats the timeout compare.
          if (!en) begin
            state_q  <= MEAS_IDLE;
            cnt_q    <= '0;
            hi_cnt_q <= '0;
          end else if (rise) begin
            period_q <= cnt_q + CNT_ONE;
            high_q   <= hi_cnt_q;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
            hi_cnt_q <= CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= MEAS_IDLE;
            cnt_q     <= '0;
            hi_cnt_q  <= '0;
          end else begin
            cnt_q    <= cnt_q + CNT_ONE;
            hi_cnt_q <= hi_cnt_q + CNT_WIDTH'(level);
          end
        end
        default: begin
          state_q  <= MEAS_IDLE;
          cnt_q    <= '0;
          hi_cnt_q <= '0;
        end
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

  always_comb begin
    dbg_o       = '0;
    dbg_o.state = state_q;
    dbg_o.level = level;
    dbg_o.rise  = rise;
    dbg_o.fall  = fall;
  end

endmodule
